// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - three-button synchronizer, debouncer, press detector and go/up latches
//
// Optional feature macro: BUTTON_AUTOREPEAT_EN (auto-repeat on button 2).
//
// Ports:
//   clk        - system clock, all flops on rising edge
//   reset_n    - synchronous active-low reset
//   bt_raw     - [2:0] asynchronous raw buttons, active-low
//   level      - [2:0] debounced state, active-high
//   press_tick - [2:0] one-cycle pulse per accepted press
//   clear_tick - copy of press_tick[0] (stopwatch clear)
//   go         - run/stop latch (toggled by button 1, cleared by button 0)
//   up         - count direction latch (toggled by button 2), 1 = up

module button_conditioner #(
    parameter int DB_COUNT     = 240000,
    parameter int DB_WIDTH     = 18,
    parameter int REPEAT_COUNT = 3000000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] bt_raw,
    output logic [2:0] level,
    output logic [2:0] press_tick,
    output logic       clear_tick,
    output logic       go,
    output logic       up
);

    localparam logic [DB_WIDTH-1:0] DB_LAST = DB_WIDTH'(DB_COUNT - 1);

    logic [2:0] sync1;
    logic [2:0] sync2;
    logic [2:0] s;
    logic [2:0] level_prev;
    logic [2:0] rise;
    logic       rep_fire;

    // Synchronizer idles at 1 so that reset looks like "all released".
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1 <= 3'b111;
            sync2 <= 3'b111;
        end else begin
            sync1 <= bt_raw;
            sync2 <= sync1;
        end
    end

    assign s = ~sync2;

    // Per-button debouncer: any sample equal to the accepted level restarts
    // the count, so only DB_COUNT consecutive differing samples are accepted.
    for (genvar i = 0; i < 3; i++) begin : g_db
        logic [DB_WIDTH-1:0] cnt;
        logic                lvl_q;

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                cnt   <= '0;
                lvl_q <= 1'b0;
            end else if (s[i] == lvl_q) begin
                cnt <= '0;
            end else if (cnt == DB_LAST) begin
                lvl_q <= s[i];
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end

        assign level[i] = lvl_q;
    end

    assign rise = level & ~level_prev;

`ifdef BUTTON_AUTOREPEAT_EN
    localparam int RW = (REPEAT_COUNT > 1) ? $clog2(REPEAT_COUNT) : 1;
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_COUNT - 1);

    logic [RW-1:0] rep_cnt;

    // Phase-aligned to the initial tick: the counter is zeroed on the cycle
    // the rising edge is detected, so each repeat lands REPEAT_COUNT cycles
    // after the previous tick.
    always_ff @(posedge clk) begin
        if (!reset_n || !level[2] || rise[2]) begin
            rep_cnt <= '0;
        end else if (rep_cnt == REP_LAST) begin
            rep_cnt <= '0;
        end else begin
            rep_cnt <= rep_cnt + 1'b1;
        end
    end

    assign rep_fire = level[2] && level_prev[2] && (rep_cnt == REP_LAST);
`else
    assign rep_fire = 1'b0;
`endif

    // Tick stage: pulses appear the cycle after the debounced level rises.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            level_prev <= 3'b000;
            press_tick <= 3'b000;
            clear_tick <= 1'b0;
        end else begin
            level_prev <= level;
            press_tick <= {rise[2] | rep_fire, rise[1], rise[0]};
            clear_tick <= rise[0];
        end
    end

    // Clear has priority over run/stop when both land in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            go <= 1'b0;
            up <= 1'b1;
        end else begin
            if (press_tick[0]) begin
                go <= 1'b0;
            end else if (press_tick[1]) begin
                go <= ~go;
            end
            if (press_tick[2]) begin
                up <= ~up;
            end
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - directed table and sequence bench for button_conditioner

module tb_button_conditioner;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [2:0] bt_raw;
    logic [2:0] level;
    logic [2:0] press_tick;
    logic       clear_tick;
    logic       go;
    logic       up;

    int n_vec = 0;
    int n_err = 0;

    button_conditioner #(
        .DB_COUNT    (4),
        .DB_WIDTH    (3),
        .REPEAT_COUNT(10)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bt_raw    (bt_raw),
        .level     (level),
        .press_tick(press_tick),
        .clear_tick(clear_tick),
        .go        (go),
        .up        (up)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [2:0] bt;
        logic [2:0] lvl;
        logic [2:0] pt;
        logic       go;
        logic       up;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ticks;
        int first_at;
        bit found;
        int exp_ticks;
        logic exp_up;

        reset_n = 1'b0;
        bt_raw  = 3'b111;

        // Reset then clean press of button 1; rows are state after each edge.
        vecs[0]  = '{1'b0, 3'b111, 3'b000, 3'b000, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 3'b111, 3'b000, 3'b000, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 3'b101, 3'b000, 3'b000, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 3'b101, 3'b000, 3'b000, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 3'b101, 3'b000, 3'b000, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 3'b101, 3'b000, 3'b000, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 3'b101, 3'b000, 3'b000, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 3'b101, 3'b010, 3'b000, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 3'b101, 3'b010, 3'b010, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 3'b101, 3'b010, 3'b000, 1'b1, 1'b1};
        vecs[10] = '{1'b1, 3'b101, 3'b010, 3'b000, 1'b1, 1'b1};

        for (int v = 0; v < 11; v++) begin
            reset_n = vecs[v].rst_n;
            bt_raw  = vecs[v].bt;
            step();
            chk($sformatf("v%0d_level", v), 32'(level), 32'(vecs[v].lvl));
            chk($sformatf("v%0d_tick", v), 32'(press_tick), 32'(vecs[v].pt));
            chk($sformatf("v%0d_clear", v), 32'(clear_tick), 32'(vecs[v].pt[0]));
            chk($sformatf("v%0d_go", v), 32'(go), 32'(vecs[v].go));
            chk($sformatf("v%0d_up", v), 32'(up), 32'(vecs[v].up));
        end

        // Bounce on button 2, then settle pressed.
        for (int c = 0; c < 20; c++) begin
            bt_raw[2] = ((c / 2) % 2 == 0) ? 1'b0 : 1'b1;
            step();
            chk("bounce_tick", 32'(press_tick[2]), 32'd0);
            chk("bounce_level", 32'(level[2]), 32'd0);
        end
        bt_raw[2] = 1'b0;
        ticks = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (press_tick[2]) ticks++;
        end
        chk("settle_ticks", 32'(ticks), 32'd1);
        chk("settle_up", 32'(up), 32'd0);

        // Release of button 2: level falls on the 6th edge, no tick.
        bt_raw[2] = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("rel_level_e%0d", k), 32'(level[2]), (k < 6) ? 32'd1 : 32'd0);
            chk("rel_tick", 32'(press_tick[2]), 32'd0);
        end

        // Clear priority: go=1, buttons 0 and 1 pressed together.
        bt_raw = 3'b111;
        repeat (8) step();
        chk("pre_clear_go", 32'(go), 32'd1);
        bt_raw = 3'b100;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            if (press_tick[0]) begin
                found = 1'b1;
                chk("clr_tick1", 32'(press_tick[1]), 32'd1);
                chk("clr_clear_tick", 32'(clear_tick), 32'd1);
            end
        end
        chk("clr_found", 32'(found), 32'd1);
        step();
        chk("clr_go", 32'(go), 32'd0);

        // Reset in the middle of a debounce on button 1.
        bt_raw = 3'b111;
        repeat (8) step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        chk("mid_go_reset", 32'(go), 32'd0);
        bt_raw = 3'b101;
        repeat (3) step();
        reset_n = 1'b0;
        step();
        chk("mid_level_reset", 32'(level), 32'd0);
        reset_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            chk($sformatf("mid_level_e%0d", k), 32'(level[1]), (k == 6) ? 32'd1 : 32'd0);
        end
        step();
        step();
        chk("mid_go", 32'(go), 32'd1);

        // Button 2 held 35 cycles past acceptance.
        bt_raw = 3'b111;
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        bt_raw = 3'b011;
        ticks = 0;
        first_at = 0;
        for (int k = 1; k <= 41; k++) begin
            step();
            if (press_tick[2]) begin
                ticks++;
                if (first_at == 0) first_at = k;
            end
        end
`ifdef BUTTON_AUTOREPEAT_EN
        exp_ticks = 4;
        exp_up = 1'b1;
`else
        exp_ticks = 1;
        exp_up = 1'b0;
`endif
        chk("hold_first_tick_edge", 32'(first_at), 32'd7);
        chk("hold_ticks", 32'(ticks), 32'(exp_ticks));
        chk("hold_up", 32'(up), 32'(exp_up));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
